// File: rtl/debouncer_bank_if.sv
// Raw key inputs and debounced outputs for a debouncer_bank instance.
interface debouncer_bank_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] x;
  logic [N-1:0] z;
  logic [N-1:0] ev;
  logic [N-1:0] long;

  modport master (output x, input z, input ev, input long);
  modport slave  (input x, output z, output ev, output long);
endinterface

// File: rtl/debouncer_bank.sv
// N-channel key debouncer: 2-flop synchroniser, stability counter,
// single-cycle edge event and long-press flag per channel.
module debouncer_bank #(
  parameter int unsigned N      = 4,
  parameter int unsigned DELAY  = 50000,
  parameter int unsigned HOLD   = 0,
  parameter bit          DETECT = 1'b1,
  parameter bit          MODE   = 1'b1,
  parameter bit          INIT   = 1'b0
) (
  input  logic             ck,
  input  logic             reset,
  debouncer_bank_if.slave  bus
);
  localparam int unsigned CW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int unsigned HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);

  logic [N-1:0]  s1;
  logic [N-1:0]  s2;
  logic [N-1:0]  z_q;
  logic [N-1:0]  ev_q;
  logic [N-1:0]  long_q;
  logic [N-1:0]  flip_c;
  logic [N-1:0]  z_next_c;
  logic [CW-1:0] cnt [N];

  // A channel flips when its synchronised sample has differed for DELAY samples.
  always_comb begin
    flip_c = '0;
    for (int i = 0; i < N; i++) begin
      flip_c[i] = (s2[i] != z_q[i]) && (cnt[i] == CNT_LAST);
    end
    z_next_c = z_q ^ flip_c;
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      s1   <= {N{INIT}};
      s2   <= {N{INIT}};
      z_q  <= {N{INIT}};
      ev_q <= {N{~MODE}};
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1  <= bus.x;
      s2  <= s1;
      z_q <= z_next_c;
      for (int i = 0; i < N; i++) begin
        // Agreement or a completed change both restart the run.
        if ((s2[i] == z_q[i]) || flip_c[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
        ev_q[i] <= (flip_c[i] && (s2[i] == DETECT)) ? MODE : ~MODE;
      end
    end
  end

  if (HOLD != 0) begin : g_hold
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD);

    logic [HW-1:0] hcnt    [N];
    logic [HW-1:0] hnext_c [N];

    // Count edges spent at the active level; clear when leaving it.
    always_comb begin
      for (int i = 0; i < N; i++) begin
        hnext_c[i] = '0;
        if ((z_q[i] == DETECT) && (z_next_c[i] == DETECT)) begin
          hnext_c[i] = (hcnt[i] == HOLD_MAX) ? hcnt[i] : hcnt[i] + HW'(1);
        end
      end
    end

    always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
        long_q <= '0;
        for (int i = 0; i < N; i++) begin
          hcnt[i] <= '0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          hcnt[i]   <= hnext_c[i];
          long_q[i] <= (hnext_c[i] == HOLD_MAX);
        end
      end
    end
  end else begin : g_no_hold
    assign long_q = '0;
  end

  assign bus.z    = z_q;
  assign bus.ev   = ev_q;
  assign bus.long = long_q;
endmodule

// File: tb/tb_debouncer_bank.sv
// Randomised and directed bench for debouncer_bank: an active-high and an
// active-low instance checked every cycle against a sample-history model.
module tb_debouncer_bank;
  localparam int DELAY = 5;
  localparam int HOLD  = 10;

  logic       ck = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] xm = 4'h0;
  logic [3:0] xv = 4'hF;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_q [$];

  debouncer_bank_if #(.N(4)) bm ();
  debouncer_bank_if #(.N(4)) bv ();

  assign bm.x = xm;
  assign bv.x = xv;

  debouncer_bank #(.N(4), .DELAY(DELAY), .HOLD(HOLD),
                   .DETECT(1'b1), .MODE(1'b1), .INIT(1'b0))
    dut_m (.ck(ck), .reset(rst), .bus(bm.slave));

  debouncer_bank #(.N(4), .DELAY(DELAY), .HOLD(HOLD),
                   .DETECT(1'b0), .MODE(1'b0), .INIT(1'b1))
    dut_v (.ck(ck), .reset(rst), .bus(bv.slave));

  always #10 ck = ~ck;

  // Reference model: [dut][channel], dut 0 = active-high, dut 1 = active-low.
  int h0 [2][4];
  int h1 [2][4];
  int mz [2][4];
  int run [2][4];
  int act [2][4];
  int mev [2][4];
  int mlong [2][4];

  function automatic int det_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic int mode_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic int init_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        h0[d][i]    = init_of(d);
        h1[d][i]    = init_of(d);
        mz[d][i]    = init_of(d);
        run[d][i]   = 0;
        act[d][i]   = 0;
        mev[d][i]   = 1 - mode_of(d);
        mlong[d][i] = 0;
      end
    end
  endtask

  // One clock edge: the sample seen is x from two edges ago.
  task automatic model_step(input int d, input logic [3:0] xin);
    int s;
    int zo;
    bit flipped;
    for (int i = 0; i < 4; i++) begin
      s        = h1[d][i];
      h1[d][i] = h0[d][i];
      h0[d][i] = int'(xin[i]);
      zo       = mz[d][i];
      flipped  = 1'b0;
      if (s != mz[d][i]) begin
        run[d][i] = run[d][i] + 1;
        if (run[d][i] == DELAY) begin
          mz[d][i]  = s;
          run[d][i] = 0;
          flipped   = 1'b1;
        end
      end else begin
        run[d][i] = 0;
      end
      mev[d][i] = (flipped && mz[d][i] == det_of(d)) ? mode_of(d) : 1 - mode_of(d);
      if (zo == det_of(d) && mz[d][i] == det_of(d)) act[d][i] = act[d][i] + 1;
      else act[d][i] = 0;
      mlong[d][i] = (HOLD != 0 && act[d][i] >= HOLD) ? 1 : 0;
    end
  endtask

  function automatic logic [11:0] pack_exp(input int d);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[8 + i] = mz[d][i][0];
      r[4 + i] = mev[d][i][0];
      r[i]     = mlong[d][i][0];
    end
    return r;
  endfunction

  // Drive one cycle: model the edge, then apply reset changes and new x.
  task automatic tick(input logic [3:0] nm, input logic [3:0] nv,
                      input bit rst_assert, input bit rst_release);
    @(posedge ck);
    if (!rst) begin
      model_step(0, xm);
      model_step(1, xv);
    end
    #2;
    if (rst_assert) begin
      rst = 1'b1;
      model_reset();
    end
    if (rst_release) rst = 1'b0;
    xm = nm;
    xv = nv;
    exp_q.push_back({pack_exp(0), pack_exp(1)});
  endtask

  task automatic run_for(input logic [3:0] nm, input logic [3:0] nv, input int n);
    repeat (n) tick(nm, nv, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the DUTs present a result, pop and compare.
  always @(negedge ck) begin
    logic [23:0] e;
    logic [23:0] a;
    string       nm;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty at %0t: no expected entry queued", $time);
    end else begin
      e = exp_q.pop_front();
      a = {bm.z, bm.ev, bm.long, bv.z, bv.ev, bv.long};
      for (int k = 0; k < 6; k++) begin
        case (k)
          0: nm = "z_main";
          1: nm = "ev_main";
          2: nm = "long_main";
          3: nm = "z_var";
          4: nm = "ev_var";
          default: nm = "long_var";
        endcase
        n_checks++;
        if (a[23 - 4*k -: 4] !== e[23 - 4*k -: 4]) begin
          n_fail++;
          $display("FAIL %s at %0t: got %h expected %h", nm, $time,
                   a[23 - 4*k -: 4], e[23 - 4*k -: 4]);
        end
      end
    end
  end

  initial begin
    int durs [9];
    int remm [4];
    int remv [4];
    int rst_hold;
    logic [3:0] nm;
    logic [3:0] nv;
    bit ra;
    bit rr;

    durs = '{1, 2, 3, 4, 5, 6, 8, 12, 25};
    #1;
    rst = 1'b1;
    model_reset();
    tick(4'h0, 4'hF, 1'b0, 1'b1);
    run_for(4'h0, 4'hF, 10);

    // Glitch on channel 0: four samples high never reach z.
    run_for(4'h1, 4'hF, 4);
    run_for(4'h0, 4'hF, 12);

    // Bounce on channel 2 restarts the count.
    run_for(4'h4, 4'hF, 4);
    run_for(4'h0, 4'hF, 1);
    run_for(4'h4, 4'hF, 20);
    run_for(4'h0, 4'hF, 15);

    // Clean press/release on channel 0.
    run_for(4'h1, 4'hF, 30);
    run_for(4'h0, 4'hF, 15);

    // Long presses on channel 1: 25 cycles, then 12 cycles.
    run_for(4'h2, 4'hF, 25);
    run_for(4'h0, 4'hF, 15);
    run_for(4'h2, 4'hF, 12);
    run_for(4'h0, 4'hF, 15);

    // Active-low instance: channels 2 and 3 together, then channel 0 short hold.
    run_for(4'h0, 4'h3, 25);
    run_for(4'h0, 4'hF, 15);
    run_for(4'h0, 4'hE, 12);
    run_for(4'h0, 4'hF, 15);
    run_for(4'h0, 4'hD, 3);
    run_for(4'h0, 4'hF, 10);

    // Reset mid-count with inputs at the non-reset level, held through release.
    run_for(4'hF, 4'h0, 4);
    tick(4'hF, 4'h0, 1'b1, 1'b0);
    tick(4'hF, 4'h0, 1'b0, 1'b0);
    tick(4'hF, 4'h0, 1'b0, 1'b1);
    run_for(4'hF, 4'h0, 20);
    run_for(4'h0, 4'hF, 15);

    // Random per-channel toggling with occasional resets.
    for (int i = 0; i < 4; i++) begin
      remm[i] = durs[$urandom_range(0, 8)];
      remv[i] = durs[$urandom_range(0, 8)];
    end
    rst_hold = 0;
    for (int c = 0; c < 1200; c++) begin
      nm = xm;
      nv = xv;
      for (int i = 0; i < 4; i++) begin
        if (remm[i] == 0) begin
          nm[i]   = ~nm[i];
          remm[i] = durs[$urandom_range(0, 8)];
        end else remm[i]--;
        if (remv[i] == 0) begin
          nv[i]   = ~nv[i];
          remv[i] = durs[$urandom_range(0, 8)];
        end else remv[i]--;
      end
      ra = 1'b0;
      rr = 1'b0;
      if (rst_hold > 0) begin
        rst_hold--;
        rr = (rst_hold == 0);
      end else if ($urandom_range(0, 299) == 0) begin
        ra = 1'b1;
        rst_hold = int'($urandom_range(1, 2));
      end
      tick(nm, nv, ra, rr);
    end
    if (rst) tick(xm, xv, 1'b0, 1'b1);
    run_for(4'h0, 4'hF, 20);

    @(negedge ck);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
